// File: rtl/bnn_pkg.sv
// Shared types and constants for the BNN layer chain and its scheduler.
package bnn_pkg;

  localparam int unsigned CLASS_W     = 4;
  localparam int unsigned NUM_CLASSES = 10;

  // Frame scheduler FSM states
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LAUNCH  = 3'd1,
    ST_GRANT   = 3'd2,
    ST_COLLECT = 3'd3,
    ST_RELEASE = 3'd4,
    ST_PUSH    = 3'd5
  } sched_state_t;

endpackage

// File: rtl/bnn_frame_scheduler_if.sv
// Handshake and result bus between the frame scheduler, the layer chain and the host.
// master: scheduler side; slave: layer chain / host side.
interface bnn_frame_scheduler_if;
  import bnn_pkg::*;

  logic               lyr_rcv_req;
  logic               lyr_rcv_ack;
  logic               out_snd_req;
  logic               out_snd_ack;
  logic [CLASS_W-1:0] out_class;
  logic               res_valid;
  logic [CLASS_W-1:0] res_class;
  logic               res_ready;

  modport master (
    input  lyr_rcv_req, out_snd_ack, out_class, res_ready,
    output lyr_rcv_ack, out_snd_req, res_valid, res_class
  );

  modport slave (
    output lyr_rcv_req, out_snd_ack, out_class, res_ready,
    input  lyr_rcv_ack, out_snd_req, res_valid, res_class
  );
endinterface

// File: rtl/bnn_res_fifo.sv
// Synchronous result FIFO (power-of-2 depth) with full/empty/count status.
// A push into a full FIFO is refused even when a pop happens in the same cycle.
module bnn_res_fifo
  import bnn_pkg::*;
#(
  parameter int unsigned WIDTH = CLASS_W,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     xrst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q;
  logic [AW-1:0]    rd_q;
  logic [AW:0]      cnt_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign data_o  = mem_q[rd_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Storage, pointers and occupancy
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= wr_q + AW'(1);
      end
      if (do_pop) rd_q <= rd_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/bnn_frame_scheduler.sv
// Frame scheduler: queues frame starts, grants one frame at a time to the first
// layer, collects the class from the output layer and buffers it for the host.
// Optional watchdog: define BNN_SCHED_TIMEOUT_EN.
module bnn_frame_scheduler
  import bnn_pkg::*;
#(
  parameter int unsigned PEND_MAX    = 3,
  parameter int unsigned RES_DEPTH   = 4,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                  clk,
  input  logic                  xrst,
  input  logic                  frame_start,
  bnn_frame_scheduler_if.master bus,
  output logic [CNT_W-1:0]      res_count,
  output logic                  busy,
  output logic                  err_ovf,
  output logic                  err_timeout
);

  localparam int unsigned PEND_W = 4;

  sched_state_t             state_q, state_d;
  logic [PEND_W-1:0]        pend_q, pend_d;
  logic [CLASS_W-1:0]       class_q, class_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     ovf_q, ovf_d;
  logic                     grant_done;
  logic                     push;
  logic                     abort_dec;
  logic                     tmo_abort;
  logic                     pend_inc;
  logic                     pend_dec;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [$clog2(RES_DEPTH):0] fifo_count_unused;

`ifdef BNN_SCHED_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_q;
  logic             tmo_err_q;
  logic             tmo_active;

  assign tmo_active = (state_q == ST_LAUNCH) || (state_q == ST_GRANT) ||
                      (state_q == ST_COLLECT) || (state_q == ST_RELEASE);
`endif

  // Next state, class capture and handshake completion decode
  always_comb begin
    state_d    = state_q;
    class_d    = class_q;
    grant_done = 1'b0;
    push       = 1'b0;
    abort_dec  = 1'b0;
    tmo_abort  = 1'b0;
    case (state_q)
      ST_IDLE:    if (pend_q != '0) state_d = ST_LAUNCH;
      ST_LAUNCH:  if (bus.lyr_rcv_req) state_d = ST_GRANT;
      ST_GRANT: begin
        if (!bus.lyr_rcv_req) begin
          state_d    = ST_COLLECT;
          grant_done = 1'b1;
        end
      end
      ST_COLLECT: begin
        if (bus.out_snd_ack) begin
          class_d = bus.out_class;
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: if (!bus.out_snd_ack) state_d = ST_PUSH;
      ST_PUSH: begin
        if (!fifo_full) begin
          push    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default:    state_d = ST_IDLE;
    endcase
`ifdef BNN_SCHED_TIMEOUT_EN
    // A handshake completing on the limit cycle wins over the abort
    if (tmo_active && (state_d == state_q) && (tmo_q == TMO_W'(TIMEOUT_CYC - 1))) begin
      tmo_abort = 1'b1;
      state_d   = ST_IDLE;
      abort_dec = (state_q == ST_LAUNCH) || (state_q == ST_GRANT);
    end
`endif
  end

  // Pending-start counter, overflow flag and completed-frame counter
  always_comb begin
    pend_inc = frame_start && (pend_q != PEND_W'(PEND_MAX));
    pend_dec = grant_done || abort_dec;
    pend_d   = pend_q;
    if (pend_inc && !pend_dec)      pend_d = pend_q + PEND_W'(1);
    else if (!pend_inc && pend_dec) pend_d = pend_q - PEND_W'(1);
    ovf_d = ovf_q || (frame_start && (pend_q == PEND_W'(PEND_MAX)));
    cnt_d = push ? cnt_q + CNT_W'(1) : cnt_q;
  end

  // Scheduler state registers
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      state_q <= ST_IDLE;
      pend_q  <= '0;
      class_q <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      class_q <= class_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

`ifdef BNN_SCHED_TIMEOUT_EN
  // Per-phase watchdog, cleared on every state change
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      tmo_q     <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      tmo_q <= (tmo_active && (state_d == state_q)) ? tmo_q + TMO_W'(1) : '0;
      if (tmo_abort) tmo_err_q <= 1'b1;
    end
  end

  assign err_timeout = tmo_err_q;
`else
  // Watchdog limit only matters in the timeout build; kept so both builds share one parameter list
  localparam int unsigned TIMEOUT_CYC_UNUSED = TIMEOUT_CYC;
  assign err_timeout = 1'b0;
`endif

  bnn_res_fifo #(
    .WIDTH (CLASS_W),
    .DEPTH (RES_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .xrst    (xrst),
    .push_i  (push),
    .data_i  (class_q),
    .pop_i   (bus.res_ready),
    .data_o  (bus.res_class),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count_unused)
  );

  assign bus.lyr_rcv_ack = (state_q == ST_GRANT);
  assign bus.out_snd_req = (state_q == ST_COLLECT);
  assign bus.res_valid   = !fifo_empty;
  assign res_count       = cnt_q;
  assign busy            = (state_q != ST_IDLE) || (pend_q != '0);
  assign err_ovf         = ovf_q;

endmodule

// File: tb/tb_bnn_frame_scheduler.sv
// Self-checking bench for bnn_frame_scheduler with layer/output handshake models
// and a result scoreboard.
module tb_bnn_frame_scheduler;
  import bnn_pkg::*;

  logic        clk = 1'b0;
  logic        xrst;
  logic        frame_start;
  logic [15:0] res_count;
  logic        busy;
  logic        err_ovf;
  logic        err_timeout;

  int errors  = 0;
  int checks  = 0;
  int grants  = 0;
  int results = 0;

  bit lyr_en   = 1'b1;
  bit lyr_hold = 1'b0;
  bit out_en   = 1'b1;

  logic [3:0] plan_q [$];
  logic [3:0] exp_q  [$];

  bnn_frame_scheduler_if bus ();

  bnn_frame_scheduler #(
    .PEND_MAX    (3),
    .RES_DEPTH   (4),
    .CNT_W       (16),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk         (clk),
    .xrst        (xrst),
    .frame_start (frame_start),
    .bus         (bus),
    .res_count   (res_count),
    .busy        (busy),
    .err_ovf     (err_ovf),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic wait_idle(string tag);
    int n;
    n = 0;
    while (busy && n < 500) begin
      tick();
      n++;
    end
    check(tag, busy, 0);
  endtask

  task automatic drain(string tag);
    int n;
    n = 0;
    bus.res_ready = 1'b1;
    while (bus.res_valid && n < 100) begin
      tick();
      n++;
    end
    bus.res_ready = 1'b0;
    check(tag, bus.res_valid, 0);
  endtask

  // First layer: raises rcv_req when ready, drops it once granted
  initial begin
    bus.lyr_rcv_req = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!xrst) bus.lyr_rcv_req = 1'b0;
      else if (bus.lyr_rcv_req && bus.lyr_rcv_ack && !lyr_hold) begin
        bus.lyr_rcv_req = 1'b0;
        grants++;
      end else if (!bus.lyr_rcv_req && !bus.lyr_rcv_ack && lyr_en)
        bus.lyr_rcv_req = 1'b1;
    end
  end

  // Output layer: answers snd_req with the next planned class
  initial begin
    bus.out_snd_ack = 1'b0;
    bus.out_class   = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!xrst) bus.out_snd_ack = 1'b0;
      else if (!bus.out_snd_ack && bus.out_snd_req && out_en) begin
        if (plan_q.size() != 0) bus.out_class = plan_q.pop_front();
        else                    bus.out_class = 4'hF;
        bus.out_snd_ack = 1'b1;
        results++;
      end else if (bus.out_snd_ack && !bus.out_snd_req)
        bus.out_snd_ack = 1'b0;
    end
  end

  // Host-side scoreboard: each accepted pop is compared with the oldest expected class
  always @(negedge clk) begin
    if (xrst && bus.res_valid && bus.res_ready) begin
      if (exp_q.size() == 0) check("sb_unexpected_pop", exp_q.size(), 1);
      else                   check("res_class", bus.res_class, exp_q.pop_front());
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int n;
    int r0;
    xrst          = 1'b0;
    frame_start   = 1'b0;
    bus.res_ready = 1'b0;
    repeat (3) tick();

    // Reset state
    check("rst_lyr_ack", bus.lyr_rcv_ack, 0);
    check("rst_snd_req", bus.out_snd_req, 0);
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_res_count", res_count, 0);
    check("rst_busy", busy, 0);
    check("rst_err_ovf", err_ovf, 0);
    check("rst_err_tmo", err_timeout, 0);
    xrst = 1'b1;
    repeat (2) tick();

    // Single frame, class 7
    bus.res_ready = 1'b1;
    plan_q.push_back(4'd7);
    exp_q.push_back(4'd7);
    pulse_start();
    check("t1_busy_on", busy, 1);
    wait_idle("t1_idle");
    repeat (2) tick();
    check("t1_count", res_count, 1);
    check("t1_grants", grants, 1);
    check("t1_results", results, 1);
    check("t1_valid_low", bus.res_valid, 0);

    // Four back-to-back starts: the fourth overflows
    for (int i = 1; i <= 3; i++) begin
      plan_q.push_back(4'(i));
      exp_q.push_back(4'(i));
    end
    frame_start = 1'b1;
    repeat (4) tick();
    frame_start = 1'b0;
    check("t2_ovf", err_ovf, 1);
    wait_idle("t2_idle");
    repeat (3) tick();
    check("t2_count", res_count, 4);
    check("t2_grants", grants, 4);
    check("t2_results", results, 4);

    // FIFO back-pressure: five frames into a depth-4 FIFO
    bus.res_ready = 1'b0;
    r0 = results;
    for (int i = 0; i < 4; i++) begin
      plan_q.push_back(4'(i));
      exp_q.push_back(4'(i));
      pulse_start();
      wait_idle("t3_idle");
    end
    plan_q.push_back(4'd4);
    exp_q.push_back(4'd4);
    pulse_start();
    n = 0;
    while (results != r0 + 5 && n < 100) begin
      tick();
      n++;
    end
    check("t3_result5", results, r0 + 5);
    repeat (8) tick();
    check("t3_hold_count", res_count, 8);
    check("t3_hold_busy", busy, 1);
    check("t3_head_stable", bus.res_class, 0);
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    repeat (2) tick();
    check("t3_count_after_pop", res_count, 9);
    check("t3_busy_after_pop", busy, 0);
    check("t3_new_head", bus.res_class, 1);
    drain("t3_drain");

    // Simultaneous push and pop with two entries stored
    for (int i = 8; i <= 9; i++) begin
      plan_q.push_back(4'(i));
      exp_q.push_back(4'(i));
      pulse_start();
      wait_idle("t4_idle");
    end
    plan_q.push_back(4'd10);
    exp_q.push_back(4'd10);
    pulse_start();
    n = 0;
    while (dut.state_q != ST_PUSH && n < 100) begin
      tick();
      n++;
    end
    check("t4_reach_push", dut.state_q, ST_PUSH);
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    check("t4_occupancy", dut.u_fifo.cnt_q, 2);
    check("t4_head", bus.res_class, 9);
    check("t4_count", res_count, 12);
    drain("t4_drain");

    // Reset mid-grant with a result buffered and a start pending
    plan_q.push_back(4'd5);
    pulse_start();
    wait_idle("t5_idle");
    check("t5_buffered", bus.res_valid, 1);
    lyr_hold = 1'b1;
    frame_start = 1'b1;
    repeat (2) tick();
    frame_start = 1'b0;
    n = 0;
    while (!bus.lyr_rcv_ack && n < 100) begin
      tick();
      n++;
    end
    check("t5_ack_high", bus.lyr_rcv_ack, 1);
    #2;
    xrst = 1'b0;
    #1;
    check("t5_ack_async", bus.lyr_rcv_ack, 0);
    check("t5_snd_req", bus.out_snd_req, 0);
    check("t5_busy", busy, 0);
    check("t5_res_valid", bus.res_valid, 0);
    check("t5_count", res_count, 0);
    check("t5_ovf", err_ovf, 0);
    check("t5_tmo", err_timeout, 0);
    plan_q.delete();
    exp_q.delete();
    tick();
    lyr_hold = 1'b0;
    xrst = 1'b1;
    repeat (2) tick();

`ifdef BNN_SCHED_TIMEOUT_EN
    // Watchdog: output layer never answers
    out_en = 1'b0;
    pulse_start();
    n = 0;
    while (!bus.out_snd_req && n < 100) begin
      tick();
      n++;
    end
    check("t6_collect", bus.out_snd_req, 1);
    n = 0;
    while (!err_timeout && n < 100) begin
      tick();
      n++;
    end
    check("t6_tmo_cycles", n, 16);
    check("t6_tmo_flag", err_timeout, 1);
    check("t6_snd_req", bus.out_snd_req, 0);
    check("t6_idle", busy, 0);
    tick();
    check("t6_no_push", bus.res_valid, 0);
    check("t6_count", res_count, 0);
    out_en = 1'b1;
`endif

    repeat (3) tick();
    check("sb_left", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
